// File: rtl/output_image.sv
// Reassembles a raster stream of filtered pixels into a ROWS x COLS 8-bit frame buffer with a 1-cycle read port.
// Define OUTPUT_IMAGE_SAT_EN to clamp pixels to 0..255; otherwise the low byte is stored.
module output_image #(
  parameter int unsigned ROWS = 512,
  parameter int unsigned COLS = 512
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    pix_valid,
  input  logic [15:0]             pix_data,
  output logic                    pix_ready,
  output logic [$clog2(ROWS)-1:0] wr_row,
  output logic [$clog2(COLS)-1:0] wr_col,
  output logic                    image_done,
  input  logic                    rd_en,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  input  logic [$clog2(COLS)-1:0] rd_col,
  output logic [7:0]              rd_data,
  output logic                    rd_valid
);

  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FULL
  } state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic              done_q, done_d;
  logic              rd_valid_q;
  logic [PIX_W-1:0]  rd_data_q;
  logic [PIX_W-1:0]  pix_conv;
  logic              hs;
  logic              last_pix;
  logic              row_oor;
  logic              col_oor;
  logic              rd_oor;

  logic [PIX_W-1:0]  mem_q [ROWS][COLS];

  // Signed filter result to stored pixel
`ifdef OUTPUT_IMAGE_SAT_EN
  always_comb begin
    if (pix_data[15]) begin
      pix_conv = '0;
    end else if (|pix_data[14:8]) begin
      pix_conv = '1;
    end else begin
      pix_conv = pix_data[7:0];
    end
  end
`else
  logic unused_pix_msbs;
  assign unused_pix_msbs = ^pix_data[15:8];
  assign pix_conv        = pix_data[7:0];
`endif

  assign hs       = pix_valid & pix_ready;
  assign last_pix = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));

  // Out-of-range read detection only exists for non power-of-two dimensions
  if (ROWS == 2 ** RW) begin : g_row_full
    assign row_oor = 1'b0;
  end else begin : g_row_part
    assign row_oor = (rd_row > RW'(ROWS - 1));
  end

  if (COLS == 2 ** CW) begin : g_col_full
    assign col_oor = 1'b0;
  end else begin : g_col_part
    assign col_oor = (rd_col > CW'(COLS - 1));
  end

  assign rd_oor = row_oor | col_oor;

  // Next-state, write position and ready
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    pix_ready = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) state_d = COLLECT;
      end
      COLLECT: begin
        pix_ready = enable;
        if (hs) begin
          if (col_q == CW'(COLS - 1)) begin
            col_d = '0;
            row_d = last_pix ? '0 : row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (last_pix) state_d = FULL;
        end
      end
      FULL: begin
        state_d = FULL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Dropping enable abandons the frame from any state
    if (!enable) begin
      state_d = IDLE;
      row_d   = '0;
      col_d   = '0;
    end

    done_d = (state_d == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      done_q     <= done_d;
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= rd_oor ? '0 : mem_q[rd_row][rd_col];
      end
    end
  end

  // Frame storage is never reset; a same-address read sees the old value
  always_ff @(posedge clk) begin
    if (hs) begin
      mem_q[row_q][col_q] <= pix_conv;
    end
  end

  assign wr_row     = row_q;
  assign wr_col     = col_q;
  assign image_done = done_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_output_image.sv
// Randomized self-checking bench for output_image (4x4 frame, plus a 3x3 instance for out-of-range reads).
module tb_output_image;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;
  localparam int unsigned NPIX = ROWS * COLS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        rd_en;
  logic [1:0]  rd_row;
  logic [1:0]  rd_col;

  logic        pix_ready, image_done, rd_valid;
  logic [1:0]  wr_row, wr_col;
  logic [7:0]  rd_data;

  logic        pix_ready_b, image_done_b, rd_valid_b;
  logic [1:0]  wr_row_b, wr_col_b;
  logic [7:0]  rd_data_b;

  int ntests = 0;
  int nfail  = 0;

  // Frame model: linear write position, frame started/complete flags, known pixel contents
  int         pos;
  bit         active;
  bit         done;
  logic [7:0] mmem [NPIX];
  bit         mknown [NPIX];
  logic [7:0] e_rd_data;
  bit         e_rd_known;
  bit         e_rd_valid;

  output_image #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .wr_row(wr_row), .wr_col(wr_col), .image_done(image_done),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  output_image #(.ROWS(3), .COLS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready_b), .wr_row(wr_row_b), .wr_col(wr_col_b), .image_done(image_done_b),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] conv(input logic [15:0] d);
    int v;
    v = int'($signed(d));
`ifdef OUTPUT_IMAGE_SAT_EN
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
`endif
    return 8'(v);
  endfunction

  function automatic void model_clear();
    pos    = 0;
    active = 1'b0;
    done   = 1'b0;
  endfunction

  // Advance one clock, applying the frame rules to the model with the inputs currently driven
  task automatic cycle();
    int idx;
    if (rd_en) begin
      idx        = int'(rd_row) * COLS + int'(rd_col);
      e_rd_valid = 1'b1;
      e_rd_data  = mmem[idx];
      e_rd_known = mknown[idx];
    end else begin
      e_rd_valid = 1'b0;
    end
    if (!enable) begin
      model_clear();
    end else begin
      if (active && !done && pix_valid) begin
        mmem[pos]   = conv(pix_data);
        mknown[pos] = 1'b1;
        pos++;
        if (pos == NPIX) begin
          pos  = 0;
          done = 1'b1;
        end
      end
      active = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic restart_frame();
    pix_valid = 1'b0;
    rd_en     = 1'b0;
    enable    = 1'b0;
    cycle();
    enable = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; pix_valid = 1'b0; pix_data = '0;
    rd_en = 1'b0; rd_row = '0; rd_col = '0;
    for (int i = 0; i < NPIX; i++) mknown[i] = 1'b0;
    model_clear();
    e_rd_data = 8'd0; e_rd_known = 1'b1; e_rd_valid = 1'b0;
    #12;
    ntests++; if (wr_row !== 2'd0) begin nfail++; $display("FAIL reset_wr_row: got %0d want 0", wr_row); end
    ntests++; if (wr_col !== 2'd0) begin nfail++; $display("FAIL reset_wr_col: got %0d want 0", wr_col); end
    ntests++; if (image_done !== 1'b0) begin nfail++; $display("FAIL reset_image_done: got %b want 0", image_done); end
    ntests++; if (rd_valid !== 1'b0) begin nfail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    ntests++; if (rd_data !== 8'd0) begin nfail++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
    ntests++; if (pix_ready !== 1'b0) begin nfail++; $display("FAIL reset_pix_ready: got %b want 0", pix_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    enable = 1'b1;
    cycle();
    ntests++; if (pix_ready !== 1'b1) begin nfail++; $display("FAIL fill_ready: got %b want 1", pix_ready); end
    for (int i = 0; i < NPIX; i++) begin
      pix_valid = 1'b1;
      pix_data  = 16'(i);
      cycle();
      ntests++; if (wr_row !== 2'(pos / COLS) || wr_col !== 2'(pos % COLS)) begin
        nfail++; $display("FAIL fill_pos[%0d]: got (%0d,%0d) want (%0d,%0d)", i, wr_row, wr_col, pos / COLS, pos % COLS);
      end
      ntests++; if (image_done !== done) begin nfail++; $display("FAIL fill_done[%0d]: got %b want %b", i, image_done, done); end
    end
    pix_valid = 1'b0;
    ntests++; if (image_done !== 1'b1) begin nfail++; $display("FAIL fill_done_final: got %b want 1", image_done); end
    rd_en = 1'b1; rd_row = 2'd2; rd_col = 2'd3;
    cycle();
    ntests++; if (rd_valid !== 1'b1 || rd_data !== 8'd11) begin
      nfail++; $display("FAIL fill_read23: got valid=%b data=%0d want valid=1 data=11", rd_valid, rd_data);
    end
    rd_en = 1'b0;
    cycle();
    ntests++; if (rd_valid !== 1'b0 || rd_data !== 8'd11) begin
      nfail++; $display("FAIL fill_read_hold: got valid=%b data=%0d want valid=0 data=11", rd_valid, rd_data);
    end
  endtask

  // Alternating valid beats with random reads, some aimed at the address being written
  task automatic test_toggle();
    int beats;
    int n;
    restart_frame();
    ntests++; if (image_done !== 1'b0 || wr_row !== 2'd0 || wr_col !== 2'd0) begin
      nfail++; $display("FAIL toggle_restart: got done=%b pos=(%0d,%0d) want 0 (0,0)", image_done, wr_row, wr_col);
    end
    beats = 0;
    n = 0;
    while (beats < NPIX && n < 100) begin
      pix_valid = n[0] ? 1'b0 : 1'b1;
      pix_data  = 16'($urandom);
      rd_en     = 1'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        rd_row = 2'(pos / COLS); rd_col = 2'(pos % COLS);
      end else begin
        rd_row = 2'($urandom); rd_col = 2'($urandom);
      end
      if (pix_valid) beats++;
      cycle();
      n++;
      ntests++; if (wr_row !== 2'(pos / COLS) || wr_col !== 2'(pos % COLS) || image_done !== done) begin
        nfail++; $display("FAIL toggle_pos[%0d]: got (%0d,%0d) done=%b want (%0d,%0d) done=%b",
                          n, wr_row, wr_col, image_done, pos / COLS, pos % COLS, done);
      end
      ntests++; if (rd_valid !== e_rd_valid || (e_rd_known && rd_data !== e_rd_data)) begin
        nfail++; $display("FAIL toggle_read[%0d]: got valid=%b data=%0d want valid=%b data=%0d",
                          n, rd_valid, rd_data, e_rd_valid, e_rd_data);
      end
    end
    pix_valid = 1'b0;
    ntests++; if (beats != NPIX || image_done !== 1'b1) begin
      nfail++; $display("FAIL toggle_complete: got beats=%0d done=%b want beats=%0d done=1", beats, image_done, NPIX);
    end
    for (int i = 0; i < NPIX; i++) begin
      rd_en = 1'b1; rd_row = 2'(i / COLS); rd_col = 2'(i % COLS);
      cycle();
      ntests++; if (rd_valid !== 1'b1 || rd_data !== e_rd_data) begin
        nfail++; $display("FAIL toggle_readback[%0d]: got %0d want %0d", i, rd_data, e_rd_data);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_conversion();
    logic [15:0] din [3];
    logic [7:0]  exp_c [3];
    din[0] = 16'hFFFB; din[1] = 16'd300; din[2] = 16'd128;
`ifdef OUTPUT_IMAGE_SAT_EN
    exp_c[0] = 8'd0;   exp_c[1] = 8'd255; exp_c[2] = 8'd128;
`else
    exp_c[0] = 8'd251; exp_c[1] = 8'd44;  exp_c[2] = 8'd128;
`endif
    restart_frame();
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1'b1; pix_data = din[i];
      cycle();
    end
    pix_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1; rd_row = 2'd0; rd_col = 2'(i);
      cycle();
      ntests++; if (rd_valid !== 1'b1 || rd_data !== exp_c[i]) begin
        nfail++; $display("FAIL conv[%0d]: got %0d want %0d", i, rd_data, exp_c[i]);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_abandon();
    logic [7:0] v11;
    logic [7:0] vnew;
    restart_frame();
    for (int i = 0; i < 6; i++) begin
      pix_valid = 1'b1; pix_data = 16'($urandom);
      cycle();
    end
    pix_valid = 1'b0;
    v11 = mmem[5];
    enable = 1'b0;
    cycle();
    ntests++; if (image_done !== 1'b0 || wr_row !== 2'd0 || wr_col !== 2'd0 || pix_ready !== 1'b0) begin
      nfail++; $display("FAIL abandon_clear: got done=%b pos=(%0d,%0d) ready=%b want 0 (0,0) 0",
                        image_done, wr_row, wr_col, pix_ready);
    end
    enable = 1'b1;
    rd_en = 1'b1; rd_row = 2'd1; rd_col = 2'd1;
    cycle();
    ntests++; if (rd_data !== v11) begin nfail++; $display("FAIL abandon_keep11: got %0d want %0d", rd_data, v11); end
    rd_en = 1'b0;
    pix_valid = 1'b1; pix_data = 16'($urandom);
    vnew = conv(pix_data);
    cycle();
    pix_valid = 1'b0;
    ntests++; if (wr_row !== 2'd0 || wr_col !== 2'd1) begin
      nfail++; $display("FAIL abandon_restart_pos: got (%0d,%0d) want (0,1)", wr_row, wr_col);
    end
    rd_en = 1'b1; rd_row = 2'd0; rd_col = 2'd0;
    cycle();
    ntests++; if (rd_data !== vnew) begin nfail++; $display("FAIL abandon_new00: got %0d want %0d", rd_data, vnew); end
    rd_row = 2'd1; rd_col = 2'd1;
    cycle();
    ntests++; if (rd_data !== v11) begin nfail++; $display("FAIL abandon_still11: got %0d want %0d", rd_data, v11); end
    rd_en = 1'b0;
  endtask

  // Completes the frame left by test_abandon, then offers pixels while full
  task automatic test_full();
    while (!done && pos != 0 || (!done && pos == 0 && active)) begin
      pix_valid = 1'b1; pix_data = 16'($urandom);
      cycle();
      if (done) break;
    end
    ntests++; if (image_done !== 1'b1) begin nfail++; $display("FAIL full_done: got %b want 1", image_done); end
    pix_valid = 1'b1; pix_data = 16'd99;
    #1;
    ntests++; if (pix_ready !== 1'b0) begin nfail++; $display("FAIL full_ready: got %b want 0", pix_ready); end
    for (int i = 0; i < NPIX; i++) begin
      rd_en = 1'b1; rd_row = 2'(i / COLS); rd_col = 2'(i % COLS);
      cycle();
      ntests++; if (rd_valid !== 1'b1 || rd_data !== e_rd_data || image_done !== 1'b1) begin
        nfail++; $display("FAIL full_hold[%0d]: got %0d done=%b want %0d done=1", i, rd_data, image_done, e_rd_data);
      end
    end
    pix_valid = 1'b0;
    rd_row = 2'd3; rd_col = 2'($urandom);
    cycle();
    ntests++; if (rd_valid_b !== 1'b1 || rd_data_b !== 8'd0) begin
      nfail++; $display("FAIL oor_row: got valid=%b data=%0d want valid=1 data=0", rd_valid_b, rd_data_b);
    end
    rd_row = 2'd0; rd_col = 2'd3;
    cycle();
    ntests++; if (rd_valid_b !== 1'b1 || rd_data_b !== 8'd0) begin
      nfail++; $display("FAIL oor_col: got valid=%b data=%0d want valid=1 data=0", rd_valid_b, rd_data_b);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_async_reset();
    restart_frame();
    for (int i = 0; i < 5; i++) begin
      pix_valid = 1'b1;
      pix_data  = (i == 0) ? 16'($urandom_range(255, 1)) : 16'($urandom);
      cycle();
    end
    pix_valid = 1'b0;
    rd_en = 1'b1; rd_row = 2'd0; rd_col = 2'd0;
    cycle();
    ntests++; if (rd_valid !== 1'b1 || rd_data !== e_rd_data) begin
      nfail++; $display("FAIL areset_pre: got %0d want %0d", rd_data, e_rd_data);
    end
    #3;
    rst_n = 1'b0;
    #1;
    ntests++; if (wr_row !== 2'd0 || wr_col !== 2'd0 || image_done !== 1'b0) begin
      nfail++; $display("FAIL areset_pos: got (%0d,%0d) done=%b want (0,0) 0", wr_row, wr_col, image_done);
    end
    ntests++; if (rd_valid !== 1'b0 || rd_data !== 8'd0 || pix_ready !== 1'b0) begin
      nfail++; $display("FAIL areset_rd: got valid=%b data=%0d ready=%b want 0 0 0", rd_valid, rd_data, pix_ready);
    end
    model_clear();
    e_rd_valid = 1'b0; e_rd_data = 8'd0; e_rd_known = 1'b1;
    rd_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();
    for (int i = 0; i < NPIX; i++) begin
      rd_en = 1'b1; rd_row = 2'(i / COLS); rd_col = 2'(i % COLS);
      cycle();
      ntests++; if (rd_data !== e_rd_data) begin
        nfail++; $display("FAIL areset_retain[%0d]: got %0d want %0d", i, rd_data, e_rd_data);
      end
    end
    rd_en = 1'b0;
    pix_valid = 1'b1; pix_data = 16'($urandom);
    cycle();
    pix_valid = 1'b0;
    rd_en = 1'b1; rd_row = 2'd0; rd_col = 2'd0;
    cycle();
    ntests++; if (rd_data !== e_rd_data || wr_col !== 2'd1 || wr_row !== 2'd0) begin
      nfail++; $display("FAIL areset_restart: got data=%0d pos=(%0d,%0d) want data=%0d pos=(0,1)",
                        rd_data, wr_row, wr_col, e_rd_data);
    end
    rd_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_toggle();
    test_conversion();
    test_abandon();
    test_full();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
